column_drop_locator: RTL and testbench
======================================

COLUMN_DROP_LOCATOR -- requirements
Module: column_drop_locator

Interface
REQ-001 Parameter COLS, default 4, board columns.
REQ-002 Parameter ROWS, default 4, board rows; cell index = row*COLS + col, row 0 = bottom.
REQ-003 Parameter NO_SEL, default 5'b11111, "no selection" code on column_position.
REQ-004 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 Port reset, input, 1, synchronous, active-high reset.
REQ-006 Port col_btn, input, COLS, per-column push buttons, synchronized levels, 1 = pressed.
REQ-007 Port state, input, 2, game FSM state: GAME_INIT=00, P1_TURN=01, P2_TURN=10, END_GAME=11.
REQ-008 Port gameboard, input, 16, occupancy map, 1 = cell taken.
REQ-009 Port column_position, output, 5, registered landing cell index, else NO_SEL.
REQ-010 Port busy, output, 1, high in any state other than IDLE.
REQ-011 Port col_full, output, 1, one-cycle pulse when the requested column has no empty cell.

Function
REQ-012 FSM states SHALL be IDLE, SCAN, PRESENT, WAIT_RELEASE.
REQ-013 A press SHALL be a rising edge (current 1, previous-cycle 0) on exactly one col_btn bit while all other bits are 0.
REQ-014 Presses with two or more bits rising or already high SHALL be ignored; the FSM goes to WAIT_RELEASE.
REQ-015 IDLE: a valid press while state is P1_TURN or P2_TURN SHALL latch the column, clear the row counter to 0, and enter SCAN on the next edge.
REQ-016 Presses while state is GAME_INIT or END_GAME SHALL be ignored.
REQ-017 SCAN: each cycle, test gameboard[row*COLS+col]:
  - 0: load column_position with that index and enter PRESENT.
  - 1 and row<ROWS-1: increment row.
  - 1 and row==ROWS-1: pulse col_full for one cycle and enter WAIT_RELEASE.
REQ-018 Landing latency SHALL be (r+2) cycles from the press edge to column_position valid, where r = landing row.
REQ-019 PRESENT SHALL hold column_position valid for exactly one cycle, then restore NO_SEL and enter WAIT_RELEASE.
REQ-020 WAIT_RELEASE SHALL return to IDLE only in a cycle where all col_btn bits are 0; a held button SHALL never retrigger.
REQ-021 Outside PRESENT, column_position SHALL equal NO_SEL.
REQ-022 col_full and column_position SHALL never be non-NO_SEL/high in the same cycle.
REQ-023 state becoming GAME_INIT in any FSM state SHALL force IDLE and NO_SEL on the next edge (abort mid-scan), with no col_full pulse.
REQ-024 gameboard changing during SCAN SHALL be used as sampled in each cycle; no snapshot.
REQ-025 Row counter width SHALL be clog2(ROWS) and SHALL NOT wrap past ROWS-1.

Reset
REQ-026 On reset: FSM=IDLE, column_position=NO_SEL, busy=0, col_full=0, row=0, latched column=0.
REQ-027 On reset, the previous-button register SHALL load all-ones, so a button held through reset is not a press.

Structure
REQ-028 State encodings GAME_INIT/P1_TURN/P2_TURN/END_GAME and NO_SEL SHALL live in the shared game package, also used by the column selector.
REQ-029 Edge detection and one-hot checking SHALL be one sub-module, btn_edge_detect (outputs press_valid, press_col, any_held).

Verification
REQ-030 Empty board, state=01, col_btn 0000->0100: column_position=2 exactly 2 cycles after the edge, for 1 cycle; then NO_SEL.
REQ-031 gameboard=16'h0111, state=10, press col 0: rows 0-2 skipped; column_position=12 five cycles after the edge.
REQ-032 gameboard=16'h2222, press col 1: col_full pulses 1 cycle, 5 cycles after the edge; column_position stays NO_SEL.
REQ-033 Press col 3 and hold 20 cycles: exactly one valid index (3); no retrigger until release and a new press.
REQ-034 col_btn 0000->0011, then state=11 with a single press: both ignored, busy behaviour per REQ-014/REQ-016.
REQ-035 Mid-SCAN (gameboard=16'h0111), state forced to 00, then reset asserted mid-PRESENT: IDLE/NO_SEL next edge, no col_full.

Source files
------------

// File: rtl/column_drop_locator_pkg.sv
// Shared game definitions: turn-state encodings, the no-selection code and the
// drop locator's own FSM states.
package column_drop_locator_pkg;

  localparam int unsigned POS_W   = 5;
  localparam int unsigned BOARD_W = 16;
  localparam int unsigned BIDX_W  = 4;

  localparam logic [POS_W-1:0] NO_SEL_CODE = 5'b11111;

  typedef enum logic [1:0] {
    GAME_INIT = 2'b00,
    P1_TURN   = 2'b01,
    P2_TURN   = 2'b10,
    END_GAME  = 2'b11
  } game_state_e;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    SCAN         = 2'b01,
    PRESENT      = 2'b10,
    WAIT_RELEASE = 2'b11
  } drop_state_e;

  // True while a player may drop a piece.
  function automatic logic is_turn(input logic [1:0] s);
    return (s == P1_TURN) || (s == P2_TURN);
  endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Column button press detector: registers a single clean rising edge, its
// column index, and whether any button is currently held.
module btn_edge_detect #(
  parameter int unsigned COLS  = 4,
  parameter int unsigned COL_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [COLS-1:0]  col_btn,
  output logic             press_valid,
  output logic [COL_W-1:0] press_col,
  output logic             any_held
);

  logic [COLS-1:0]  prev_q;
  logic [COLS-1:0]  rise;
  logic             single_hot;
  logic             valid_now;
  logic [COL_W-1:0] enc;

  // A press is exactly one button high, and that button was low last cycle.
  always_comb begin
    rise       = col_btn & ~prev_q;
    single_hot = (col_btn != '0) && ((col_btn & (col_btn - COLS'(1))) == '0);
    valid_now  = single_hot && (rise == col_btn);
    enc        = '0;
    for (int i = 0; i < int'(COLS); i++) begin
      if (col_btn[i]) begin
        enc = COL_W'(i);
      end
    end
  end

  // prev_q resets to all ones so a button held through reset never counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q      <= '1;
      press_valid <= 1'b0;
      press_col   <= '0;
      any_held    <= 1'b0;
    end else begin
      prev_q      <= col_btn;
      press_valid <= valid_now;
      press_col   <= enc;
      any_held    <= |col_btn;
    end
  end

endmodule

// File: rtl/column_drop_locator.sv
// Finds the lowest empty cell in the pressed column and presents its index
// for one cycle, or pulses col_full when the column has no room.
module column_drop_locator
  import column_drop_locator_pkg::*;
#(
  parameter int unsigned     COLS   = 4,
  parameter int unsigned     ROWS   = 4,
  parameter logic [POS_W-1:0] NO_SEL = NO_SEL_CODE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COLS-1:0]    col_btn,
  input  logic [1:0]         state,
  input  logic [BOARD_W-1:0] gameboard,
  output logic [POS_W-1:0]   column_position,
  output logic               busy,
  output logic               col_full
);

  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  drop_state_e       fsm_q, fsm_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [POS_W-1:0]  pos_d;
  logic              full_d;
  logic              busy_d;

  logic              press_valid;
  logic [COL_W-1:0]  press_col;
  logic              any_held;

  logic [POS_W-1:0]  cell_idx;
  logic [BIDX_W-1:0] board_idx;
  logic              cell_taken;

  btn_edge_detect #(
    .COLS  (COLS),
    .COL_W (COL_W)
  ) u_btn_edge_detect (
    .clk         (clk),
    .reset       (reset),
    .col_btn     (col_btn),
    .press_valid (press_valid),
    .press_col   (press_col),
    .any_held    (any_held)
  );

  // Cell under test; the board is read live every scan cycle.
  always_comb begin
    cell_idx   = POS_W'(row_q) * POS_W'(COLS) + POS_W'(col_q);
    board_idx  = BIDX_W'(row_q) * BIDX_W'(COLS) + BIDX_W'(col_q);
    cell_taken = gameboard[board_idx];
  end

  always_comb begin
    fsm_d  = fsm_q;
    row_d  = row_q;
    col_d  = col_q;
    pos_d  = NO_SEL;
    full_d = 1'b0;

    if (state == GAME_INIT) begin
      fsm_d = IDLE;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (is_turn(state)) begin
            if (press_valid) begin
              col_d = press_col;
              row_d = '0;
              fsm_d = SCAN;
            end else if (any_held) begin
              fsm_d = WAIT_RELEASE;
            end
          end
        end
        SCAN: begin
          if (!cell_taken) begin
            pos_d = cell_idx;
            fsm_d = PRESENT;
          end else if (row_q != ROW_W'(ROWS - 1)) begin
            row_d = row_q + ROW_W'(1);
          end else begin
            full_d = 1'b1;
            fsm_d  = WAIT_RELEASE;
          end
        end
        PRESENT: begin
          fsm_d = WAIT_RELEASE;
        end
        WAIT_RELEASE: begin
          if (col_btn == '0) begin
            fsm_d = IDLE;
          end
        end
        default: begin
          fsm_d = IDLE;
        end
      endcase
    end

    busy_d = (fsm_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q           <= IDLE;
      row_q           <= '0;
      col_q           <= '0;
      column_position <= NO_SEL;
      busy            <= 1'b0;
      col_full        <= 1'b0;
    end else begin
      fsm_q           <= fsm_d;
      row_q           <= row_d;
      col_q           <= col_d;
      column_position <= pos_d;
      busy            <= busy_d;
      col_full        <= full_d;
    end
  end

endmodule

// File: tb/tb_column_drop_locator.sv
// Bench for column_drop_locator: directed scenarios plus random boards checked
// against a lowest-empty-row reference model.
module tb_column_drop_locator;

  localparam int COLS = 4;
  localparam int ROWS = 4;
  localparam int WIN  = ROWS + 4;
  localparam logic [4:0] NSEL = 5'b11111;

  logic        clk;
  logic        reset;
  logic [3:0]  col_btn;
  logic [1:0]  state;
  logic [15:0] gameboard;
  logic [4:0]  column_position;
  logic        busy;
  logic        col_full;

  int checks;
  int errors;

  column_drop_locator #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .NO_SEL (NSEL)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .col_btn         (col_btn),
    .state           (state),
    .gameboard       (gameboard),
    .column_position (column_position),
    .busy            (busy),
    .col_full        (col_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Lowest empty row of a column, or -1 when the column is full.
  function automatic int landing_row(input logic [15:0] board, input int col);
    for (int r = 0; r < ROWS; r++) begin
      if (!board[r * COLS + col]) return r;
    end
    return -1;
  endfunction

  // Press one column on a static board, hold it, release, and check every cycle.
  task automatic press_and_check(input logic [15:0] board, input logic [1:0] st,
                                 input int col, input int extra_hold);
    int r;
    int idx;
    logic exp_full;
    logic [4:0] exp_pos;
    gameboard = board;
    state     = st;
    r         = landing_row(board, col);
    exp_full  = (r < 0);
    idx       = exp_full ? 0 : r * COLS + col;
    col_btn   = '0;
    col_btn[col] = 1'b1;
    tick();
    check("press_edge_pos", 32'(column_position), 32'(NSEL));
    check("press_edge_busy", 32'(busy), 32'd0);
    for (int k = 1; k <= WIN; k++) begin
      tick();
      exp_pos = (!exp_full && k == r + 2) ? 5'(idx) : NSEL;
      check("scan_pos", 32'(column_position), 32'(exp_pos));
      check("scan_full", 32'(col_full), 32'(exp_full && k == ROWS + 1));
      check("scan_busy", 32'(busy), 32'd1);
    end
    for (int k = 0; k < extra_hold; k++) begin
      tick();
      check("hold_pos", 32'(column_position), 32'(NSEL));
      check("hold_busy", 32'(busy), 32'd1);
    end
    col_btn = '0;
    tick();
    check("release_busy", 32'(busy), 32'd0);
    check("release_pos", 32'(column_position), 32'(NSEL));
    tick();
  endtask

  initial begin
    logic [15:0] rb;
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    state     = 2'b01;
    gameboard = '0;
    col_btn   = 4'b0001;

    // Reset values, with a button held straight through reset.
    tick(); tick(); tick();
    check("reset_pos", 32'(column_position), 32'(NSEL));
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_full", 32'(col_full), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < WIN; k++) begin
      tick();
      check("held_thru_reset_pos", 32'(column_position), 32'(NSEL));
      check("held_thru_reset_full", 32'(col_full), 32'd0);
    end
    col_btn = '0;
    tick(); tick();
    check("held_release_busy", 32'(busy), 32'd0);

    // Directed landing cases.
    press_and_check(16'h0000, 2'b01, 2, 0);
    press_and_check(16'h0111, 2'b10, 0, 0);
    press_and_check(16'h2222, 2'b01, 1, 0);
    press_and_check(16'h0000, 2'b01, 3, 12);

    // Two buttons at once: ignored, waits for release.
    gameboard = '0;
    state     = 2'b01;
    col_btn   = 4'b0011;
    tick();
    check("multi_edge_busy", 32'(busy), 32'd0);
    for (int k = 1; k <= WIN; k++) begin
      tick();
      check("multi_busy", 32'(busy), 32'd1);
      check("multi_pos", 32'(column_position), 32'(NSEL));
      check("multi_full", 32'(col_full), 32'd0);
    end
    col_btn = '0;
    tick();
    check("multi_release_busy", 32'(busy), 32'd0);

    // Single press during END_GAME: ignored entirely.
    state   = 2'b11;
    col_btn = 4'b0010;
    for (int k = 0; k <= WIN; k++) begin
      tick();
      check("endgame_busy", 32'(busy), 32'd0);
      check("endgame_pos", 32'(column_position), 32'(NSEL));
      check("endgame_full", 32'(col_full), 32'd0);
    end
    col_btn = '0;
    tick(); tick();

    // Abort mid-scan by dropping to GAME_INIT.
    state     = 2'b01;
    gameboard = 16'h0111;
    col_btn   = 4'b0001;
    tick(); tick(); tick();
    check("abort_pre_busy", 32'(busy), 32'd1);
    state = 2'b00;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_pos", 32'(column_position), 32'(NSEL));
    check("abort_full", 32'(col_full), 32'd0);
    for (int k = 0; k < WIN; k++) begin
      tick();
      check("abort_after_pos", 32'(column_position), 32'(NSEL));
      check("abort_after_full", 32'(col_full), 32'd0);
      check("abort_after_busy", 32'(busy), 32'd0);
    end
    col_btn = '0;
    state   = 2'b01;
    tick(); tick();

    // Reset while presenting a result.
    gameboard = '0;
    col_btn   = 4'b0010;
    tick(); tick(); tick();
    check("present_pos", 32'(column_position), 32'd1);
    reset = 1'b1;
    tick();
    check("rst_present_pos", 32'(column_position), 32'(NSEL));
    check("rst_present_busy", 32'(busy), 32'd0);
    check("rst_present_full", 32'(col_full), 32'd0);
    col_btn = '0;
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_busy", 32'(busy), 32'd0);

    // Random boards, turns and columns.
    for (int t = 0; t < 40; t++) begin
      rb = 16'($urandom);
      press_and_check(rb, 2'($urandom_range(1, 2)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
